// File: rtl/seq_det_pkg.sv
// Shared constants for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam int PAT_LEN_MAX = 32;

    // Encoding of the overlap select input.
    localparam logic MODE_NOVL = 1'b0;
    localparam logic MODE_OVL  = 1'b1;

endpackage : seq_det_pkg

// File: rtl/seq_detect_param_if.sv
// Serial stream, control and status bundle of the pattern detector.
interface seq_detect_param_if #(
    parameter int PAT_LEN = 3,
    parameter int CNT_W   = 8
);
    logic               din;
    logic               din_vld;
    logic               overlap;
    logic               load;
    logic [PAT_LEN-1:0] pat_in;
    logic               clr_cnt;
    logic               Y;
    logic               y_q;
    logic [CNT_W-1:0]   match_cnt;
    logic [PAT_LEN-1:0] pat;

    modport master (
        output din, din_vld, overlap, load, pat_in, clr_cnt,
        input  Y, y_q, match_cnt, pat
    );

    modport slave (
        input  din, din_vld, overlap, load, pat_in, clr_cnt,
        output Y, y_q, match_cnt, pat
    );
endinterface : seq_detect_param_if

// File: rtl/seq_det_window.sv
// Bit history, fill counter and comparator; produces the Mealy match.
module seq_det_window
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    input  logic               din_vld,
    input  logic               load,
    input  logic               overlap,
    input  logic [PAT_LEN-1:0] pat,
    output logic               y
);
    localparam int                FILL_W   = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;

    // Full window only once PAT_LEN-1 bits are held; din supplies the last one.
    assign y = din_vld & ~load & (fill_q == FILL_MAX) & ({hist_q, din} == pat);

    always_comb begin
        // NOTE: defaults first so every path assigns hist_d/fill_d and no latch is inferred.
        hist_d = hist_q;
        fill_d = fill_q;
        if (load) begin
            hist_d = '0;
            fill_d = '0;
        end else if (din_vld) begin
            hist_d = (PAT_LEN - 1)'({hist_q, din});
            if (y && (overlap != MODE_OVL)) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end
endmodule : seq_det_window

// File: rtl/seq_detect_param.sv
// Serial pattern detector top: pattern register, saturating match counter, registered match.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(3'b101),
    parameter int                 CNT_W   = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    seq_detect_param_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               y_q, y_d;
    logic               y;

    seq_det_window #(
        .PAT_LEN (PAT_LEN)
    ) u_window (
        .clk     (CLK),
        .rst_n   (RST_N),
        .din     (bus.din),
        .din_vld (bus.din_vld),
        .load    (bus.load),
        .overlap (bus.overlap),
        .pat     (pat_q),
        .y       (y)
    );

    // Load outranks clear, and clear outranks a coincident match.
    always_comb begin
        pat_d = pat_q;
        cnt_d = cnt_q;
        y_d   = y;
        if (bus.load) begin
            pat_d = bus.pat_in;
            cnt_d = '0;
        end else if (bus.clr_cnt) begin
            cnt_d = '0;
        end else if (y && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pat_q <= PATTERN;
            cnt_q <= '0;
            y_q   <= 1'b0;
        end else begin
            pat_q <= pat_d;
            cnt_q <= cnt_d;
            y_q   <= y_d;
        end
    end

    assign bus.Y         = y;
    assign bus.y_q       = y_q;
    assign bus.match_cnt = cnt_q;
    assign bus.pat       = pat_q;
endmodule : seq_detect_param

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param (default build plus a 2-bit-counter build).
module tb_seq_detect_param;

    logic CLK = 1'b0;
    logic RST_N;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    seq_detect_param_if #(.PAT_LEN(3), .CNT_W(8)) a ();
    seq_detect_param_if #(.PAT_LEN(3), .CNT_W(2)) b ();

    seq_detect_param #(.PAT_LEN(3), .PATTERN(3'b101), .CNT_W(8)) dut_a (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (a)
    );

    seq_detect_param #(.PAT_LEN(3), .PATTERN(3'b111), .CNT_W(2)) dut_b (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (b)
    );

    // Inputs change on the falling edge; outputs are read 1 time unit later.
    task automatic apply_a(input logic d, input logic v);
        @(negedge CLK);
        a.din     = d;
        a.din_vld = v;
        #1;
    endtask

    task automatic apply_b(input logic d, input logic v);
        @(negedge CLK);
        b.din     = d;
        b.din_vld = v;
        #1;
    endtask

    task automatic do_reset();
        a.din = 0; a.din_vld = 0; a.overlap = 1; a.load = 0; a.pat_in = '0; a.clr_cnt = 0;
        b.din = 0; b.din_vld = 0; b.overlap = 1; b.load = 0; b.pat_in = '0; b.clr_cnt = 0;
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        RST_N = 1'b0;
        a.din = 1; a.din_vld = 1;
        #1;
        n_checks++;
        if (a.Y !== 1'b0) begin n_fail++; $display("FAIL reset_Y: got %b want 0", a.Y); end
        n_checks++;
        if (a.y_q !== 1'b0) begin n_fail++; $display("FAIL reset_y_q: got %b want 0", a.y_q); end
        n_checks++;
        if (a.match_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", a.match_cnt); end
        n_checks++;
        if (a.pat !== 3'b101) begin n_fail++; $display("FAIL reset_pat: got %b want 101", a.pat); end
        n_checks++;
        if (b.pat !== 3'b111) begin n_fail++; $display("FAIL reset_pat_b: got %b want 111", b.pat); end
        a.din_vld = 0;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // Runs stream 1,0,1,0,1 with the given overlap mode against hand-derived match positions.
    task automatic run_10101(input logic ovl, input logic [4:0] exp_y, input int final_cnt, input string tag);
        logic [4:0] stream = 5'b10101;
        int         exp_cnt = 0;
        do_reset();
        a.overlap = ovl;
        for (int i = 0; i < 5; i++) begin
            apply_a(stream[i], 1'b1);
            n_checks++;
            if (a.Y !== exp_y[i]) begin n_fail++; $display("FAIL %s_Y bit%0d: got %b want %b", tag, i + 1, a.Y, exp_y[i]); end
            n_checks++;
            if (a.y_q !== ((i > 0) ? exp_y[i-1] : 1'b0))
                begin n_fail++; $display("FAIL %s_y_q bit%0d: got %b", tag, i + 1, a.y_q); end
            n_checks++;
            if (a.match_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL %s_cnt bit%0d: got %0d want %0d", tag, i + 1, a.match_cnt, exp_cnt); end
            if (exp_y[i]) exp_cnt++;
        end
        apply_a(1'b0, 1'b0);
        n_checks++;
        if (a.Y !== 1'b0) begin n_fail++; $display("FAIL %s_idle_Y: got %b want 0", tag, a.Y); end
        n_checks++;
        if (a.y_q !== exp_y[4]) begin n_fail++; $display("FAIL %s_final_y_q: got %b want %b", tag, a.y_q, exp_y[4]); end
        n_checks++;
        if (a.match_cnt !== 8'(final_cnt)) begin n_fail++; $display("FAIL %s_final_cnt: got %0d want %0d", tag, a.match_cnt, final_cnt); end
    endtask

    task automatic test_overlap();
        run_10101(1'b1, 5'b10100, 2, "ovl");
    endtask

    task automatic test_no_overlap();
        run_10101(1'b0, 5'b00100, 1, "novl");
    endtask

    // Load 110 with a live match count, then feed 1,1,1,0 with idle gaps carrying din=0.
    task automatic test_load_gaps();
        logic [6:0] d_v  = 7'b0010101;
        logic [6:0] vl_v = 7'b1010101;
        logic [6:0] ey_v = 7'b1000000;
        @(negedge CLK);
        a.load = 1; a.pat_in = 3'b110; a.din = 1; a.din_vld = 1; a.overlap = 1;
        #1;
        n_checks++;
        if (a.Y !== 1'b0) begin n_fail++; $display("FAIL load_Y: got %b want 0", a.Y); end
        @(negedge CLK);
        a.load = 0; a.din_vld = 0;
        #1;
        n_checks++;
        if (a.pat !== 3'b110) begin n_fail++; $display("FAIL load_pat: got %b want 110", a.pat); end
        n_checks++;
        if (a.match_cnt !== 8'd0) begin n_fail++; $display("FAIL load_cnt_clr: got %0d want 0", a.match_cnt); end
        for (int i = 0; i < 7; i++) begin
            apply_a(d_v[i], vl_v[i]);
            n_checks++;
            if (a.Y !== ey_v[i]) begin n_fail++; $display("FAIL gap_Y step%0d: got %b want %b", i, a.Y, ey_v[i]); end
        end
        apply_a(1'b0, 1'b0);
        n_checks++;
        if (a.match_cnt !== 8'd1) begin n_fail++; $display("FAIL gap_cnt: got %0d want 1", a.match_cnt); end
        n_checks++;
        if (a.y_q !== 1'b1) begin n_fail++; $display("FAIL gap_y_q: got %b want 1", a.y_q); end
    endtask

    // Partial 1,0 under pattern 101 is aborted by an asynchronous reset; pat returns to 101 from 110.
    task automatic test_reset_mid();
        apply_a(1'b1, 1'b1);
        apply_a(1'b0, 1'b1);
        @(posedge CLK);
        a.din_vld = 0;
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (a.pat !== 3'b101) begin n_fail++; $display("FAIL rstmid_pat: got %b want 101", a.pat); end
        n_checks++;
        if (a.match_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d want 0", a.match_cnt); end
        n_checks++;
        if (a.y_q !== 1'b0) begin n_fail++; $display("FAIL rstmid_y_q: got %b want 0", a.y_q); end
        n_checks++;
        if (dut_a.u_window.fill_q !== 2'd0) begin n_fail++; $display("FAIL rstmid_fill: got %0d want 0", dut_a.u_window.fill_q); end
        @(negedge CLK);
        RST_N = 1'b1;
        apply_a(1'b1, 1'b1);
        n_checks++;
        if (a.Y !== 1'b0) begin n_fail++; $display("FAIL rstmid_noY: got %b want 0", a.Y); end
        apply_a(1'b0, 1'b1);
        apply_a(1'b1, 1'b1);
        n_checks++;
        if (a.Y !== 1'b1) begin n_fail++; $display("FAIL rstmid_firstY: got %b want 1", a.Y); end
        apply_a(1'b0, 1'b0);
    endtask

    // Seven 1s against 111 on a 2-bit counter: matches on bits 3..7, count pins at 3.
    task automatic test_saturate();
        logic [6:0] ey = 7'b1111100;
        int         exp_cnt = 0;
        int         n_y = 0;
        for (int i = 0; i < 7; i++) begin
            apply_b(1'b1, 1'b1);
            n_checks++;
            if (b.Y !== ey[i]) begin n_fail++; $display("FAIL sat_Y bit%0d: got %b want %b", i + 1, b.Y, ey[i]); end
            n_checks++;
            if (b.match_cnt !== 2'(exp_cnt)) begin n_fail++; $display("FAIL sat_cnt bit%0d: got %0d want %0d", i + 1, b.match_cnt, exp_cnt); end
            if (b.Y === 1'b1) n_y++;
            if (ey[i] && exp_cnt < 3) exp_cnt++;
        end
        apply_b(1'b0, 1'b0);
        n_checks++;
        if (b.match_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_final_cnt: got %0d want 3", b.match_cnt); end
        n_checks++;
        if (n_y != 5) begin n_fail++; $display("FAIL sat_y_count: got %0d want 5", n_y); end
    endtask

    // A match coinciding with clr_cnt is not counted but still registers on y_q.
    task automatic test_clr_same_cycle();
        do_reset();
        a.overlap = 1;
        apply_a(1'b1, 1'b1);
        apply_a(1'b0, 1'b1);
        @(negedge CLK);
        a.din = 1; a.clr_cnt = 1;
        #1;
        n_checks++;
        if (a.Y !== 1'b1) begin n_fail++; $display("FAIL clr_Y: got %b want 1", a.Y); end
        @(negedge CLK);
        a.clr_cnt = 0; a.din_vld = 0;
        #1;
        n_checks++;
        if (a.match_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d want 0", a.match_cnt); end
        n_checks++;
        if (a.y_q !== 1'b1) begin n_fail++; $display("FAIL clr_y_q: got %b want 1", a.y_q); end
        apply_a(1'b0, 1'b1);
        apply_a(1'b1, 1'b1);
        n_checks++;
        if (a.Y !== 1'b1) begin n_fail++; $display("FAIL clr_ovl_Y: got %b want 1", a.Y); end
        apply_a(1'b0, 1'b0);
        n_checks++;
        if (a.match_cnt !== 8'd1) begin n_fail++; $display("FAIL clr_after_cnt: got %0d want 1", a.match_cnt); end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_no_overlap();
        test_load_gaps();
        test_reset_mid();
        test_saturate();
        test_clr_same_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded 50000 time units");
        $fatal(1);
    end

endmodule : tb_seq_detect_param

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector with a run-time-loadable pattern, selectable overlapping or non-overlapping matching, and a saturating match counter. It monitors a 1-bit serial stream qualified by a valid strobe. It raises a combinational (Mealy) match output in the same cycle the final pattern bit arrives, plus a registered copy one cycle later. It replaces the fixed 3-bit detectors in the serial-input front end.

## Interface
Parameters:
- `PAT_LEN`, default 3 — pattern length in bits; legal range 2..32.
- `PATTERN`, default 3'b101 — reset value of the pattern register. MSB is the first bit received.
- `CNT_W`, default 8 — width of the match counter.

Ports:
- `CLK` input 1 — single clock; all state updates on the rising edge.
- `RST_N` input 1 — asynchronous, active-low reset.
- `din` input 1 — serial data bit.
- `din_vld` input 1 — `din` is sampled only when this is 1.
- `overlap` input 1 — 1 selects overlapping matches; 0 selects non-overlapping matches.
- `load` input 1 — load `pat_in` into the pattern register.
- `pat_in` input `PAT_LEN` — new pattern; MSB is the first bit received.
- `clr_cnt` input 1 — synchronous clear of the match counter.
- `Y` output 1 — Mealy match output; combinational from state, `din` and `din_vld`.
- `y_q` output 1 — `Y` registered.
- `match_cnt` output `CNT_W` — number of matches seen; saturates.
- `pat` output `PAT_LEN` — current pattern register.

## Operation
State:
- `hist[PAT_LEN-2:0]`: last accepted bits; the newest bit is in the LSB.
- `fill`: counts accepted bits, 0..PAT_LEN-1, saturating.
- `pat`: pattern register.
- `match_cnt`: match counter.
- `y_q`: registered match.

Match condition:
- `Y = din_vld & ~load & (fill == PAT_LEN-1) & ({hist, din} == pat)`.

Accepted bit (`din_vld`=1, `load`=0):
- `hist` shifts left, taking `din` into the LSB.
- If `Y`=0 or `overlap`=1: `fill` increments, saturating at PAT_LEN-1.
- If `Y`=1 and `overlap`=0: `fill` goes to 0, so the next match needs PAT_LEN fresh bits.

When `din_vld`=0: `hist` and `fill` hold; `Y`=0.

`load`=1 (takes priority over every other input):
- `pat` ← `pat_in`.
- `hist` ← 0, `fill` ← 0, `match_cnt` ← 0.
- `Y`=0 in that cycle; `din` is ignored.

Counter:
- `clr_cnt`=1 sets `match_cnt` to 0. If `Y`=1 in the same cycle, that match is dropped (clear wins).
- Otherwise, `Y`=1 increments `match_cnt`, saturating at 2^CNT_W−1.

Other rules:
- `y_q` ← `Y` every cycle.
- `overlap` may change on any cycle. It is evaluated only in the cycle a match occurs.

## Timing
Reset (`RST_N`=0, asynchronous, holds while low):
- `hist`=0, `fill`=0, `match_cnt`=0, `y_q`=0.
- `pat`=`PATTERN`.
- `Y`=0, because `fill`=0.

Latency:
- `Y` asserts combinationally in the cycle the final pattern bit is presented.
- `y_q` and `match_cnt` update at the next rising edge.

Boundary conditions:
- First possible match is on the PAT_LEN-th accepted bit after reset, load, or a non-overlap match.
- `din_vld` gaps are transparent: bits need not be on consecutive cycles.
- `RST_N` asserted mid-pattern aborts the partial match; no match is reported after release until PAT_LEN new accepted bits arrive.

## Structure
- `seq_det_pkg` holds `PAT_LEN_MAX` = 32 and the `overlap` encoding constants (`MODE_NOVL`=0, `MODE_OVL`=1).
- One sub-module, `seq_det_window`, holds `hist`, `fill` and the comparator, and produces `Y`.
- The top level holds `pat`, `match_cnt`, `y_q` and the load/clear priority logic.

## Test plan
- Defaults, `overlap`=1, `din_vld`=1, stream 1,0,1,0,1 → `Y`=1 on bits 3 and 5; `match_cnt`=2; `y_q` pulses one cycle after each `Y`.
- Same stream with `overlap`=0 → `Y`=1 on bit 3 only; `match_cnt`=1.
- Load `pat_in`=3'b110, then send 1,1,1,0 with `din_vld` low on alternate cycles → single `Y` on the final 0; `match_cnt`=1; `pat` reads 3'b110.
- `CNT_W`=2, overlapping pattern 3'b111, send seven 1s → `match_cnt` sequence 1,2,3,3,3; `Y` asserts 5 times.
- `clr_cnt`=1 in the same cycle as a match → `match_cnt`=0 next cycle; `y_q`=1 next cycle.
- Send 1,0, pulse `RST_N` low asynchronously mid-cycle, then send 1 → no `Y`; `y_q`, `match_cnt`, `fill` read 0; `pat`=3'b101.
